// File: rtl/shift_seq_ctrl_pkg.sv
// Shared FSM encoding and legal parameter ranges for the shift sequencer.
package shctrl_pkg;

    typedef logic [1:0] state_t;

    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_DONE  = 2'd2;

    localparam int WIDTH_MAX = 16;
    localparam int DIV_MAX   = 255;

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Start/ready/done handshake plus serial drive pins between loader, sequencer and shift register.
interface shift_seq_ctrl_if #(
    parameter int WIDTH = 4,
    parameter int CW    = $clog2(WIDTH + 1)
);
    logic             start;
    logic [WIDTH-1:0] din;
    logic             ready;
    logic             busy;
    logic             sh_en;
    logic             ser_out;
    logic [CW-1:0]    bit_cnt;
    logic             done;

    modport master (
        output start, din,
        input  ready, busy, sh_en, ser_out, bit_cnt, done
    );

    modport slave (
        input  start, din,
        output ready, busy, sh_en, ser_out, bit_cnt, done
    );
endinterface

// File: rtl/shift_seq_ctrl_tick_div.sv
// Bit-period divider: counts enabled cycles while running and flags the last one of each period.
module shctrl_tick_div #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    input  logic clear,
    input  logic run,
    output logic tick
);
    localparam int            DW   = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [DW-1:0] LAST = DW'(DIV - 1);

    logic [DW-1:0] div_cnt;

    // tick is combinational here; the sequencer registers it into sh_en
    assign tick = run && (div_cnt == LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            div_cnt <= '0;
        end else if (clk_en) begin
            if (clear) begin
                div_cnt <= '0;
            end else if (run) begin
                div_cnt <= tick ? '0 : div_cnt + DW'(1);
            end
        end
    end
endmodule

// File: rtl/shift_seq_ctrl.sv
// Serializes a parallel word into a serial-in shift register at a programmable bit rate.
// Build option: define SHCTRL_MSB_FIRST_EN for MSB-first ordering (default LSB first).
module shift_seq_ctrl
    import shctrl_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int DIV   = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic clk_en,
    shift_seq_ctrl_if.slave bus
);
    localparam int CW = $clog2(WIDTH + 1);

    if (WIDTH < 1 || WIDTH > WIDTH_MAX) begin : g_bad_width
        $error("shift_seq_ctrl: WIDTH out of legal range");
    end
    if (DIV < 1 || DIV > DIV_MAX) begin : g_bad_div
        $error("shift_seq_ctrl: DIV out of legal range");
    end

    state_t           state;
    logic [WIDTH-1:0] hold;
    logic [CW-1:0]    bit_cnt;
    logic             ready;
    logic             busy;
    logic             sh_en;
    logic             ser_out;
    logic             done;
    logic             tick;

    function automatic logic sel_bit(input logic [WIDTH-1:0] w, input logic [CW-1:0] idx);
        int               pos;
        logic [WIDTH-1:0] t;
`ifdef SHCTRL_MSB_FIRST_EN
        pos = WIDTH - 1 - int'(idx);
`else
        pos = int'(idx);
`endif
        if (pos < 0 || pos >= WIDTH) begin
            return 1'b0;
        end
        t = w >> pos;
        return t[0];
    endfunction

    shctrl_tick_div #(.DIV(DIV)) u_tick_div (
        .clk    (clk),
        .reset  (reset),
        .clk_en (clk_en),
        .clear  (state == ST_IDLE),
        .run    (state == ST_SHIFT),
        .tick   (tick)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= ST_IDLE;
            hold    <= '0;
            bit_cnt <= '0;
            ready   <= 1'b1;
            busy    <= 1'b0;
            sh_en   <= 1'b0;
            ser_out <= 1'b0;
            done    <= 1'b0;
        end else if (clk_en) begin
            case (state)
                ST_IDLE: begin
                    if (bus.start) begin
                        hold    <= bus.din;
                        bit_cnt <= '0;
                        ser_out <= sel_bit(bus.din, '0);
                        ready   <= 1'b0;
                        busy    <= 1'b1;
                        state   <= ST_SHIFT;
                    end
                end
                ST_SHIFT: begin
                    if (sh_en && (bit_cnt == CW'(WIDTH - 1))) begin
                        // last strobe consumed: suppress any coincident tick (DIV=1)
                        bit_cnt <= CW'(WIDTH);
                        sh_en   <= 1'b0;
                        ser_out <= 1'b0;
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end else begin
                        if (sh_en) begin
                            bit_cnt <= bit_cnt + CW'(1);
                            ser_out <= sel_bit(hold, bit_cnt + CW'(1));
                        end
                        sh_en <= tick;
                    end
                end
                ST_DONE: begin
                    done  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: begin
                    sh_en <= 1'b0;
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ready   = ready;
    assign bus.busy    = busy;
    assign bus.sh_en   = sh_en;
    assign bus.ser_out = ser_out;
    assign bus.bit_cnt = bit_cnt;
    assign bus.done    = done;
endmodule
